memory_arbiter: RTL

- Shares the single RAM port between instruction-fetch and data requesters of the single-cycle/pipelined MIPS core.
- Sits between the datapath's cache interface (instruction and data request/wait/load) and the RAM.
- Sequences one access at a time with an FSM and gives data requests priority.
- Alternates to a pending instruction fetch after each data completion so neither side is starved.

---
 rtl/cpu_types_pkg.sv | 6 +
 rtl/grant_timer.sv | 18 +
 rtl/memory_arbiter.sv | 72 +++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, RAM handshake and arbiter state types for the MIPS memory path.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
  typedef enum logic [1:0] {IDLE = 2'd0, DGRANT = 2'd1, IGRANT = 2'd2} arb_state_t;
endpackage

// File: rtl/grant_timer.sv
// grant_timer: counts stalled grant cycles; expired once the count reaches TIMEOUT_CYCLES.
module grant_timer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cnt_d = clear ? '0 : enable ? cnt_q + 1'b1 : cnt_q;
  assign expired = cnt_q == CNT_W'(TIMEOUT_CYCLES);
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one RAM port between instruction and data requesters, data first.
// Define MEM_TIMEOUT_EN to force completion of grants stalled for TIMEOUT_CYCLES.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        memerr
);
  arb_state_t state_q, state_d;
  logic d_req, in_d, in_i, live, acc, err, tmo, forced, done, strobe;
  word_t done_data;
  assign d_req  = dREN | dWEN;
  assign in_d   = state_q == DGRANT;
  assign in_i   = state_q == IGRANT;
  // live: the granted requester still wants the access
  assign live   = (in_d & d_req) | (in_i & iREN);
  assign acc    = live & (ramstate == ACCESS);
  assign err    = live & (ramstate == ERROR);
`ifdef MEM_TIMEOUT_EN
  logic expired;
  grant_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)) u_timer (
    .CLK(CLK), .nRST(nRST), .clear(~live | done), .enable(live & ~done), .expired(expired)
  );
  assign tmo = live & expired;
`else
  assign tmo = 1'b0;
`endif
  // a real RAM response in the expiry cycle wins over the forced completion
  assign forced    = tmo & ~acc & ~err;
  assign done      = acc | err | forced;
  assign strobe    = live & ~forced;
  assign done_data = acc ? ramload : err ? '0 : 32'hBAD0_BAD0;
  assign ramREN    = strobe & (in_i | ~dWEN);
  assign ramWEN    = strobe & in_d & dWEN;
  assign ramaddr   = live ? (in_d ? daddr : iaddr) : '0;
  assign ramstore  = ramWEN ? dstore : '0;
  assign dwait     = ~(in_d & done);
  assign iwait     = ~(in_i & done);
  assign dload     = (in_d & done) ? done_data : '0;
  assign iload     = (in_i & done) ? done_data : '0;
  assign memerr    = err | forced;
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = d_req ? DGRANT : iREN ? IGRANT : IDLE;
    else if (!live) state_d = IDLE;
    else if (done) state_d = in_d ? (iREN ? IGRANT : d_req ? DGRANT : IDLE)
                                  : (d_req ? DGRANT : iREN ? IGRANT : IDLE);
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) state_q <= IDLE;
    else state_q <= state_d;
endmodule
